// File: rtl/vram_pkg.sv
// Shared constants and types for the VRAM arbiter slice.
`timescale 1ns/1ps
package vram_pkg;
  localparam int unsigned VRAM_AW = 17;
  localparam int unsigned VRAM_DW = 8;
  localparam int unsigned STALL_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_GRD  = 2'd2,
    OWN_GWR  = 2'd3
  } owner_e;

  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between display fetch, game logic, VRAM and the arbiter.
// VRAM_ARB_STATS_EN adds the STALL_MAX statistic.
`timescale 1ns/1ps
interface vram_arbiter_if #(
  parameter int unsigned AW = vram_pkg::VRAM_AW,
  parameter int unsigned DW = vram_pkg::VRAM_DW
) ();
  logic          DISP_REQ;
  logic [AW-1:0] DISP_ADDR;
  logic          DISP_RVALID;
  logic [DW-1:0] DISP_RDATA;
  logic          GREQ;
  logic          GWE;
  logic [AW-1:0] GADDR;
  logic [DW-1:0] GWDATA;
  logic          GACK;
  logic          GRVALID;
  logic [DW-1:0] GRDATA;
  logic          WB_EMPTY;
  logic [AW-1:0] RAM_ADDR;
  logic          RAM_WE;
  logic [DW-1:0] RAM_WDATA;
  logic [DW-1:0] RAM_RDATA;

`ifdef VRAM_ARB_STATS_EN
  logic [vram_pkg::STALL_W-1:0] STALL_MAX;

  modport slave (
    input  DISP_REQ, DISP_ADDR, GREQ, GWE, GADDR, GWDATA, RAM_RDATA,
    output DISP_RVALID, DISP_RDATA, GACK, GRVALID, GRDATA, WB_EMPTY,
           RAM_ADDR, RAM_WE, RAM_WDATA, STALL_MAX
  );
  modport master (
    output DISP_REQ, DISP_ADDR, GREQ, GWE, GADDR, GWDATA, RAM_RDATA,
    input  DISP_RVALID, DISP_RDATA, GACK, GRVALID, GRDATA, WB_EMPTY,
           RAM_ADDR, RAM_WE, RAM_WDATA, STALL_MAX
  );
`else
  modport slave (
    input  DISP_REQ, DISP_ADDR, GREQ, GWE, GADDR, GWDATA, RAM_RDATA,
    output DISP_RVALID, DISP_RDATA, GACK, GRVALID, GRDATA, WB_EMPTY,
           RAM_ADDR, RAM_WE, RAM_WDATA
  );
  modport master (
    output DISP_REQ, DISP_ADDR, GREQ, GWE, GADDR, GWDATA, RAM_RDATA,
    input  DISP_RVALID, DISP_RDATA, GACK, GRVALID, GRDATA, WB_EMPTY,
           RAM_ADDR, RAM_WE, RAM_WDATA
  );
`endif
endinterface

// File: rtl/vram_wbuf.sv
// Posted game-write FIFO; head entry is visible combinationally on dout.
`timescale 1ns/1ps
module vram_wbuf
  import vram_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= PW'(wr_ptr_q + 1'b1);
      if (do_pop)  rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
      case ({do_push, do_pop})
        2'b10:   count_q <= CW'(count_q + 1'b1);
        2'b01:   count_q <= CW'(count_q - 1'b1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads win, game writes are posted and drained when idle.
// Define VRAM_ARB_STATS_EN to add the STALL_MAX game-stall statistic.
`timescale 1ns/1ps
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned AW       = VRAM_AW,
  parameter int unsigned DW       = VRAM_DW,
  parameter int unsigned WB_DEPTH = 4
) (
  input logic           CLK,
  input logic           RST,
  vram_arbiter_if.slave bus
);
  owner_e    owner_q;
  owner_e    owner_d;
  logic [AW-1:0] last_addr_q;
  logic [DW-1:0] disp_rdata_q;
  logic [DW-1:0] grdata_q;

  logic      wb_push;
  logic      wb_pop;
  logic      wb_full;
  logic      wb_empty;
  wb_entry_t wb_din;
  wb_entry_t wb_head;

  logic          gack_c;
  logic [AW-1:0] ram_addr_c;
  logic [DW-1:0] ram_wdata_c;

  vram_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .CLK   (CLK),
    .RST   (RST),
    .push  (wb_push),
    .pop   (wb_pop),
    .din   (wb_din),
    .dout  (wb_head),
    .full  (wb_full),
    .empty (wb_empty)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

  // Grant decision plus write acceptance; reads wait for an empty buffer.
  always_comb begin
    owner_d     = OWN_NONE;
    wb_push     = 1'b0;
    wb_pop      = 1'b0;
    gack_c      = 1'b0;
    ram_addr_c  = last_addr_q;
    ram_wdata_c = '0;
    wb_din.addr = VRAM_AW'(bus.GADDR);
    wb_din.data = VRAM_DW'(bus.GWDATA);

    if (bus.DISP_REQ) begin
      owner_d    = OWN_DISP;
      ram_addr_c = bus.DISP_ADDR;
    end else if (bus.GREQ && !bus.GWE && wb_empty) begin
      owner_d    = OWN_GRD;
      ram_addr_c = bus.GADDR;
      gack_c     = 1'b1;
    end else if (!wb_empty) begin
      owner_d     = OWN_GWR;
      wb_pop      = 1'b1;
      ram_addr_c  = AW'(wb_head.addr);
      ram_wdata_c = DW'(wb_head.data);
    end

    if (bus.GREQ && bus.GWE && !wb_full) begin
      wb_push = 1'b1;
      gack_c  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_addr_q  <= '0;
      disp_rdata_q <= '0;
      grdata_q     <= '0;
    end else begin
      last_addr_q <= ram_addr_c;
      if (owner_q == OWN_DISP) disp_rdata_q <= bus.RAM_RDATA;
      if (owner_q == OWN_GRD)  grdata_q     <= bus.RAM_RDATA;
    end
  end

  assign bus.RAM_ADDR    = ram_addr_c;
  assign bus.RAM_WE      = wb_pop;
  assign bus.RAM_WDATA   = ram_wdata_c;
  assign bus.GACK        = gack_c;
  assign bus.WB_EMPTY    = wb_empty;
  assign bus.DISP_RVALID = (owner_q == OWN_DISP);
  assign bus.GRVALID     = (owner_q == OWN_GRD);
  assign bus.DISP_RDATA  = (owner_q == OWN_DISP) ? bus.RAM_RDATA : disp_rdata_q;
  assign bus.GRDATA      = (owner_q == OWN_GRD)  ? bus.RAM_RDATA : grdata_q;

`ifdef VRAM_ARB_STATS_EN
  logic [STALL_W-1:0] stall_cnt_q;
  logic [STALL_W-1:0] stall_cnt_d;
  logic [STALL_W-1:0] stall_max_q;

  // Current stall run length; both it and the peak saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (gack_c)
      stall_cnt_d = '0;
    else if (bus.GREQ && (stall_cnt_q != '1))
      stall_cnt_d = STALL_W'(stall_cnt_q + 1'b1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= '0;
      stall_max_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      if (stall_cnt_d > stall_max_q) stall_max_q <= stall_cnt_d;
    end
  end

  assign bus.STALL_MAX = stall_max_q;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a registered-read VRAM model.
`timescale 1ns/1ps
module tb_vram_arbiter;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;
  localparam logic [7:0] WDAT [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  logic CLK;
  logic RST;
  int   n_assert;
  int   n_fail;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  vram_arbiter #(.AW(AW), .DW(DW), .WB_DEPTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // VRAM model: one-cycle read latency; address 0x10 is a fixed 0x5A pattern.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  always @(posedge CLK) begin
    if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
    ram_q <= (bus.RAM_ADDR == 17'h10) ? 8'h5A : mem[bus.RAM_ADDR];
  end
  assign bus.RAM_RDATA = ram_q;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_disp_rvalid"}, 32'(bus.DISP_RVALID), 32'd0);
    chk({tag, "_disp_rdata"},  32'(bus.DISP_RDATA),  32'd0);
    chk({tag, "_gack"},        32'(bus.GACK),        32'd0);
    chk({tag, "_grvalid"},     32'(bus.GRVALID),     32'd0);
    chk({tag, "_grdata"},      32'(bus.GRDATA),      32'd0);
    chk({tag, "_wb_empty"},    32'(bus.WB_EMPTY),    32'd1);
    chk({tag, "_ram_addr"},    32'(bus.RAM_ADDR),    32'd0);
    chk({tag, "_ram_we"},      32'(bus.RAM_WE),      32'd0);
    chk({tag, "_ram_wdata"},   32'(bus.RAM_WDATA),   32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    RST = 1'b1;
    bus.DISP_REQ = 1'b0; bus.DISP_ADDR = '0;
    bus.GREQ = 1'b0; bus.GWE = 1'b0; bus.GADDR = '0; bus.GWDATA = '0;

    // Reset state
    cyc(); cyc();
    #1;
    chk_idle_outputs("reset");
    cyc();
    RST = 1'b0;

    // Single display read, latency 1
    cyc();
    bus.DISP_REQ = 1'b1; bus.DISP_ADDR = 17'h10;
    #1;
    chk("d1_ram_addr", 32'(bus.RAM_ADDR), 32'h10);
    chk("d1_ram_we",   32'(bus.RAM_WE),   32'd0);
    chk("d1_wb_empty", 32'(bus.WB_EMPTY), 32'd1);
    cyc();
    bus.DISP_REQ = 1'b0;
    #1;
    chk("d1_rvalid",   32'(bus.DISP_RVALID), 32'd1);
    chk("d1_rdata",    32'(bus.DISP_RDATA),  32'h5A);
    chk("d1_wb_empty2", 32'(bus.WB_EMPTY),   32'd1);
    cyc();
    #1;
    chk("d1_rvalid_off", 32'(bus.DISP_RVALID), 32'd0);
    chk("d1_rdata_hold", 32'(bus.DISP_RDATA),  32'h5A);

    // Fill the buffer while the display holds the RAM
    bus.DISP_REQ = 1'b1; bus.DISP_ADDR = 17'h10;
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.GREQ = 1'b1; bus.GWE = 1'b1;
      bus.GADDR = 17'(17'h100 + i); bus.GWDATA = WDAT[i];
      #1;
      chk("fill_gack",   32'(bus.GACK),   32'd1);
      chk("fill_ram_we", 32'(bus.RAM_WE), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus.GADDR = 17'h104; bus.GWDATA = WDAT[4];
      #1;
      chk("full_gack",     32'(bus.GACK),     32'd0);
      chk("full_ram_we",   32'(bus.RAM_WE),   32'd0);
      chk("full_wb_empty", 32'(bus.WB_EMPTY), 32'd0);
    end
    // Drain in order; the pending 5th write is taken during the drain
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) bus.DISP_REQ = 1'b0;
      if (i == 2) bus.GREQ = 1'b0;
      #1;
      chk("drain_ram_we",   32'(bus.RAM_WE),    32'd1);
      chk("drain_ram_addr", 32'(bus.RAM_ADDR),  32'(17'h100 + i));
      chk("drain_wdata",    32'(bus.RAM_WDATA), 32'(WDAT[i]));
      chk("drain_gack",     32'(bus.GACK),      (i == 1) ? 32'd1 : 32'd0);
      chk("drain_wb_empty", 32'(bus.WB_EMPTY),  32'd0);
    end
    cyc();
    #1;
    chk("drained_ram_we",   32'(bus.RAM_WE),   32'd0);
    chk("drained_wb_empty", 32'(bus.WB_EMPTY), 32'd1);
    chk("drained_addr_hold", 32'(bus.RAM_ADDR), 32'h104);

    // Read-after-write through the buffer
    cyc();
    bus.GREQ = 1'b1; bus.GWE = 1'b1; bus.GADDR = 17'h200; bus.GWDATA = 8'hAB;
    #1;
    chk("raw_wr_gack",   32'(bus.GACK),   32'd1);
    chk("raw_no_bypass", 32'(bus.RAM_WE), 32'd0);
    cyc();
    bus.GWE = 1'b0;
    #1;
    chk("raw_rd_wait_gack", 32'(bus.GACK),     32'd0);
    chk("raw_drain_we",     32'(bus.RAM_WE),   32'd1);
    chk("raw_drain_addr",   32'(bus.RAM_ADDR), 32'h200);
    cyc();
    #1;
    chk("raw_wb_empty", 32'(bus.WB_EMPTY), 32'd1);
    chk("raw_rd_gack",  32'(bus.GACK),     32'd1);
    chk("raw_rd_addr",  32'(bus.RAM_ADDR), 32'h200);
    chk("raw_rd_we",    32'(bus.RAM_WE),   32'd0);
    chk("raw_grvalid0", 32'(bus.GRVALID),  32'd0);
    cyc();
    bus.GREQ = 1'b0;
    #1;
    chk("raw_grvalid", 32'(bus.GRVALID),     32'd1);
    chk("raw_grdata",  32'(bus.GRDATA),      32'hAB);
    chk("raw_dvalid",  32'(bus.DISP_RVALID), 32'd0);
    cyc();
    #1;
    chk("raw_grvalid_off", 32'(bus.GRVALID), 32'd0);
    chk("raw_grdata_hold", 32'(bus.GRDATA),  32'hAB);

    // Display and game read in the same cycle
    cyc();
    bus.DISP_REQ = 1'b1; bus.DISP_ADDR = 17'h10;
    bus.GREQ = 1'b1; bus.GWE = 1'b0; bus.GADDR = 17'h101;
    #1;
    chk("prio_gack", 32'(bus.GACK),     32'd0);
    chk("prio_addr", 32'(bus.RAM_ADDR), 32'h10);
    cyc();
    bus.DISP_REQ = 1'b0;
    #1;
    chk("prio_gack2",  32'(bus.GACK),        32'd1);
    chk("prio_addr2",  32'(bus.RAM_ADDR),    32'h101);
    chk("prio_dvalid", 32'(bus.DISP_RVALID), 32'd1);
    chk("prio_gvalid", 32'(bus.GRVALID),     32'd0);
    cyc();
    bus.GREQ = 1'b0;
    #1;
    chk("prio_gvalid2", 32'(bus.GRVALID),     32'd1);
    chk("prio_gdata",   32'(bus.GRDATA),      32'h22);
    chk("prio_dvalid2", 32'(bus.DISP_RVALID), 32'd0);

    // Eight alternating display/game reads
    for (int i = 0; i <= 8; i++) begin
      cyc();
      bus.DISP_REQ = 1'b0; bus.GREQ = 1'b0;
      if (i < 8) begin
        if (i % 2 == 0) begin
          bus.DISP_REQ = 1'b1; bus.DISP_ADDR = 17'h10;
        end else begin
          bus.GREQ = 1'b1; bus.GWE = 1'b0; bus.GADDR = 17'(17'h100 + i / 2);
        end
      end
      #1;
      chk("alt_gack",   32'(bus.GACK), (i < 8 && i % 2 == 1) ? 32'd1 : 32'd0);
      chk("alt_dvalid", 32'(bus.DISP_RVALID), (i > 0 && (i - 1) % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_gvalid", 32'(bus.GRVALID),     (i > 0 && (i - 1) % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0 && (i - 1) % 2 == 0) chk("alt_ddata", 32'(bus.DISP_RDATA), 32'h5A);
      if (i > 0 && (i - 1) % 2 == 1) chk("alt_gdata", 32'(bus.GRDATA), 32'(WDAT[(i - 1) / 2]));
    end

    // Reset with three buffered writes and a display read in flight
    bus.DISP_REQ = 1'b1; bus.DISP_ADDR = 17'h10;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.GREQ = 1'b1; bus.GWE = 1'b1;
      bus.GADDR = 17'(17'h300 + i); bus.GWDATA = 8'(8'hC0 + i);
      #1;
      chk("rst_fill_gack", 32'(bus.GACK), 32'd1);
    end
    cyc();
    bus.GREQ = 1'b0;
    #1;
    chk("rst_pre_wb_empty", 32'(bus.WB_EMPTY), 32'd0);
    RST = 1'b1;
    bus.DISP_REQ = 1'b0; bus.DISP_ADDR = '0;
    bus.GADDR = '0; bus.GWDATA = '0; bus.GWE = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    cyc();
    #1;
    chk_idle_outputs("rst_hold");
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk_idle_outputs("post_rst");
    end

`ifdef VRAM_ARB_STATS_EN
    // Stall statistic: 20 blocked cycles of a pending game read
    chk("stats_reset", 32'(bus.STALL_MAX), 32'd0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      bus.DISP_REQ = 1'b1; bus.DISP_ADDR = 17'h10;
      bus.GREQ = 1'b1; bus.GWE = 1'b0; bus.GADDR = 17'h100;
      #1;
      chk("stats_stall_gack", 32'(bus.GACK), 32'd0);
    end
    cyc();
    bus.DISP_REQ = 1'b0;
    #1;
    chk("stats_gack", 32'(bus.GACK), 32'd1);
    cyc();
    bus.GREQ = 1'b0;
    #1;
    chk("stats_max",     32'(bus.STALL_MAX), 32'd20);
    chk("stats_grvalid", 32'(bus.GRVALID),   32'd1);
    chk("stats_grdata",  32'(bus.GRDATA),    32'h11);
    cyc();
    #1;
    chk("stats_max_hold", 32'(bus.STALL_MAX), 32'd20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
